// File: rtl/vga_rx_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_rx_timing
// Description : Receive-side VGA timing recoverer. Samples an incoming 3-bit
//               RGB stream with active-low hsync/vsync on pixel-enable clocks,
//               measures line and frame lengths, locks once they match the
//               configured mode and emits per-pixel coordinates with a valid
//               strobe.
// Ports       : i_clk          system clock
//               i_rst_n        synchronous active-low reset
//               i_pix_en       pixel sample strobe
//               i_hsync        horizontal sync, active low
//               i_vsync        vertical sync, active low
//               i_rgb_in       pixel colour
//               o_locked       timing locked
//               o_px_valid     active-area pixel present (1-clock pulse)
//               o_px_x/o_px_y  active column / row
//               o_px_rgb       sampled colour
//               o_line_len     length of last completed line (pixels)
//               o_frame_lines  length of last completed frame (lines)
//               o_frame_done   1-clock pulse per good locked frame
//               o_sync_err     1-clock pulse on loss of lock
//               o_frame_sum    active-pixel colour sum of the last frame
// Options     : VGA_RX_SUM_EN  builds the per-frame colour accumulator;
//                              otherwise o_frame_sum is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rx_timing #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int HDAT_BEGIN  = 143,
    parameter int HDAT_END    = 783,
    parameter int VDAT_BEGIN  = 34,
    parameter int VDAT_END    = 514,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_en,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic [2:0]  i_rgb_in,
    output logic        o_locked,
    output logic        o_px_valid,
    output logic [9:0]  o_px_x,
    output logic [9:0]  o_px_y,
    output logic [2:0]  o_px_rgb,
    output logic [9:0]  o_line_len,
    output logic [9:0]  o_frame_lines,
    output logic        o_frame_done,
    output logic        o_sync_err,
    output logic [15:0] o_frame_sum
);

    localparam logic [10:0] c_H_TOTAL     = 11'(H_TOTAL);
    localparam logic [10:0] c_V_TOTAL     = 11'(V_TOTAL);
    localparam logic [9:0]  c_HDAT_BEGIN  = 10'(HDAT_BEGIN);
    localparam logic [9:0]  c_HDAT_END    = 10'(HDAT_END);
    localparam logic [9:0]  c_VDAT_BEGIN  = 10'(VDAT_BEGIN);
    localparam logic [9:0]  c_VDAT_END    = 10'(VDAT_END);
    localparam logic [3:0]  c_LOCK_FRAMES = 4'(LOCK_FRAMES);
    localparam logic [9:0]  c_CTR_MAX     = 10'd1023;
    localparam logic [9:0]  c_CTR_PRE_MAX = 10'd1022;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_good_cnt;
    logic [3:0]  w_good_cnt_next;

    logic [9:0]  r_h_ctr;
    logic [9:0]  r_v_ctr;
    logic        r_hsync_q;
    logic        r_vsync_q;     // vsync as seen at the previous h edge
    logic        r_line_bad;

    logic        w_h_edge;
    logic        w_v_edge;
    logic [10:0] w_h_len;
    logic [10:0] w_v_len;
    logic        w_h_bad;
    logic        w_h_sat;
    logic        w_v_sat;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;
    logic        w_frame_good;
    logic        w_lock_err;
    logic        w_active;
    logic        w_px_valid;
    logic        w_frame_done;
    logic        w_sync_err;

    // ------------------------------------------------------------------
    // Sync edge detection and counter next values
    // ------------------------------------------------------------------
    assign w_h_edge = ~i_hsync & r_hsync_q;
    // vsync is only examined at line starts, so a v edge is always an h edge
    assign w_v_edge = w_h_edge & ~i_vsync & r_vsync_q;

    // One wider than the counters so a saturated count never matches a total
    assign w_h_len  = {1'b0, r_h_ctr} + 11'd1;
    assign w_v_len  = {1'b0, r_v_ctr} + 11'd1;

    assign w_h_bad  = w_h_edge & (w_h_len != c_H_TOTAL);
    // "Reaching" saturation is the single step from 1022 to 1023
    assign w_h_sat  = ~w_h_edge & (r_h_ctr == c_CTR_PRE_MAX);
    assign w_v_sat  = w_h_edge & ~w_v_edge & (r_v_ctr == c_CTR_PRE_MAX);

    always_comb begin
        w_h_next = r_h_ctr;
        if (w_h_edge) begin
            w_h_next = '0;
        end else if (r_h_ctr != c_CTR_MAX) begin
            w_h_next = r_h_ctr + 10'd1;
        end
    end

    always_comb begin
        w_v_next = r_v_ctr;
        if (w_v_edge) begin
            w_v_next = '0;
        end else if (w_h_edge && (r_v_ctr != c_CTR_MAX)) begin
            w_v_next = r_v_ctr + 10'd1;
        end
    end

    // The line closed by the v edge itself belongs to the finishing frame
    assign w_frame_good = (w_v_len == c_V_TOTAL) & ~r_line_bad & ~w_h_bad;

    assign w_lock_err = (r_state == LOCKED) &
                        (w_h_bad | w_h_sat | w_v_sat | (w_v_edge & ~w_frame_good));

    assign w_active   = (w_h_next >= c_HDAT_BEGIN) & (w_h_next < c_HDAT_END) &
                        (w_v_next >= c_VDAT_BEGIN) & (w_v_next < c_VDAT_END);
    assign w_px_valid = (r_state == LOCKED) & w_active;

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= SEARCH;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_good_cnt <= w_good_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_good_cnt_next = r_good_cnt;
        w_frame_done    = 1'b0;
        w_sync_err      = 1'b0;
        if (i_pix_en) begin
            case (r_state)
                SEARCH: begin
                    if (w_v_edge) begin
                        w_state_next    = CHECK;
                        w_good_cnt_next = '0;
                    end
                end
                CHECK: begin
                    if (w_v_edge) begin
                        if (w_frame_good) begin
                            if ((r_good_cnt + 4'd1) == c_LOCK_FRAMES) begin
                                w_state_next    = LOCKED;
                                w_good_cnt_next = '0;
                            end else begin
                                w_good_cnt_next = r_good_cnt + 4'd1;
                            end
                        end else begin
                            w_good_cnt_next = '0;
                        end
                    end
                end
                LOCKED: begin
                    // An error wins over a coincident v edge: no frame_done
                    if (w_lock_err) begin
                        w_state_next = SEARCH;
                        w_sync_err   = 1'b1;
                    end else if (w_v_edge) begin
                        w_frame_done = 1'b1;
                    end
                end
                default: begin
                    w_state_next    = SEARCH;
                    w_good_cnt_next = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Counters, measurements and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h_ctr       <= '0;
            r_v_ctr       <= '0;
            r_hsync_q     <= 1'b1;
            r_vsync_q     <= 1'b1;
            r_line_bad    <= 1'b0;
            o_locked      <= 1'b0;
            o_px_valid    <= 1'b0;
            o_px_x        <= '0;
            o_px_y        <= '0;
            o_px_rgb      <= '0;
            o_line_len    <= '0;
            o_frame_lines <= '0;
            o_frame_done  <= 1'b0;
            o_sync_err    <= 1'b0;
        end else begin
            // Pulses last one clock even when samples are back to back apart
            o_px_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
            if (i_pix_en) begin
                r_hsync_q <= i_hsync;
                r_h_ctr   <= w_h_next;
                r_v_ctr   <= w_v_next;
                if (w_h_edge) begin
                    r_vsync_q  <= i_vsync;
                    o_line_len <= w_h_len[9:0];
                end
                if (w_v_edge) begin
                    o_frame_lines <= w_v_len[9:0];
                end
                if (w_v_edge) begin
                    r_line_bad <= 1'b0;
                end else if (w_h_bad || w_h_sat) begin
                    r_line_bad <= 1'b1;
                end
                o_px_valid <= w_px_valid;
                if (w_px_valid) begin
                    o_px_x   <= w_h_next - c_HDAT_BEGIN;
                    o_px_y   <= w_v_next - c_VDAT_BEGIN;
                    o_px_rgb <= i_rgb_in;
                end
                o_frame_done <= w_frame_done;
                o_sync_err   <= w_sync_err;
                o_locked     <= (w_state_next == LOCKED);
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional per-frame colour checksum
    // ------------------------------------------------------------------
`ifdef VGA_RX_SUM_EN
    logic [15:0] r_acc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc       <= '0;
            o_frame_sum <= '0;
        end else if (i_pix_en) begin
            if (r_state == SEARCH) begin
                r_acc <= '0;
            end else if ((r_state == LOCKED) && w_v_edge) begin
                o_frame_sum <= r_acc;
                r_acc       <= '0;
            end else if (w_px_valid) begin
                r_acc <= r_acc + {13'd0, i_rgb_in};
            end
        end
    end
`else
    assign o_frame_sum = '0;
`endif

endmodule
`default_nettype wire

// File: doc/vga_rx_timing.md
# vga_rx_timing

Receive-side VGA timing recoverer: samples an incoming 3-bit RGB VGA stream with active-low hsync/vsync, measures line and frame lengths, locks once they match the configured 640x480 mode, and emits per-pixel coordinates with a valid strobe. It sits downstream of the on-board VGA generator, or an external source, and feeds capture, compare and self-check logic. It runs on the 50 MHz system clock and samples only when the pixel enable is high.

## Interface
- H_TOTAL, 800, expected pixels per line
- V_TOTAL, 525, expected lines per frame
- HDAT_BEGIN, 143, first active pixel index after hsync fall
- HDAT_END, 783, first inactive pixel index (exclusive)
- VDAT_BEGIN, 34, first active line index after vsync fall
- VDAT_END, 514, first inactive line index (exclusive)
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)
- clock  in  1  50 MHz system clock
- rst_n  in  1  reset; one clock, synchronous and active-low
- pix_en  in  1  pixel sample strobe, nominally every second clock
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- rgb_in  in  3  pixel colour
- locked  out  1  timing locked
- px_valid  out  1  active-area pixel on px_x/px_y/px_rgb
- px_x  out  10  active column 0..639
- px_y  out  10  active row 0..479
- px_rgb  out  3  sampled colour
- line_len  out  10  length of the last completed line, in pixels
- frame_lines  out  10  length of the last completed frame, in lines
- frame_done  out  1  one-clock pulse per good locked frame
- sync_err  out  1  one-clock pulse on loss of lock
- frame_sum  out  16  active-pixel colour sum of the last frame

## Operation
- All state changes occur only on clocks where pix_en=1; hsync_q and vsync_q hold the previous sampled values.
- **h edge:** hsync=0 and hsync_q=1. On an h edge, line_len <= h_ctr+1 and h_ctr <= 0. Otherwise h_ctr increments, saturating at 1023.
- **Line start:** vsync is tested only on h-edge samples.
- **v edge:** vsync=0 and the vsync value at the previous h edge was 1. On a v edge, frame_lines <= v_ctr+1 and v_ctr <= 0. On any other h edge, v_ctr increments, saturating at 1023.
- **line_bad:** set on an h edge with h_ctr+1 != H_TOTAL, or when h_ctr reaches 1023. Cleared on a v edge.
- **Good frame:** frame_lines == V_TOTAL and line_bad=0 at the v edge.
- **FSM states:** SEARCH, CHECK, LOCKED. good_cnt is 4 bits.
  - SEARCH: on a v edge, go to CHECK with good_cnt=0.
  - CHECK: on a v edge, a good frame with good_cnt+1 == LOCK_FRAMES goes to LOCKED; any other good frame increments good_cnt; a bad frame clears good_cnt.
  - LOCKED: a bad h edge, h_ctr reaching 1023, v_ctr reaching 1023, or a bad frame at a v edge pulses sync_err and goes to SEARCH. A good v edge pulses frame_done.
- **Pixel output:**
  - px_valid = LOCKED, HDAT_BEGIN <= h <= HDAT_END-1, and VDAT_BEGIN <= v <= VDAT_END-1, where h and v are the updated indices of the current sample.
  - px_x = h-HDAT_BEGIN; px_y = v-VDAT_BEGIN; px_rgb = rgb_in.
  - px_x, px_y and px_rgb hold their values when px_valid=0.
- **Simultaneous events:** an error and a v edge on the same sample produce sync_err only, with no frame_done. An h edge coinciding with the 1023 saturation counts as the edge.

## Timing
- All outputs are registered and update on the clock edge that samples pix_en=1. Latency from input sample to output is 1 clock.
- px_valid, frame_done and sync_err are high for exactly 1 clock.
- locked rises on the clock of the (LOCK_FRAMES+1)-th v edge after leaving SEARCH. It falls together with sync_err.
- **Reset:** rst_n=0 at a rising edge clears all outputs and counters to 0, the FSM to SEARCH, and hsync_q/vsync_q to 1. This applies mid-frame as well; lock is always reacquired from scratch.

## Configuration
- **VGA_RX_SUM_EN defined:**
  - A 16-bit accumulator adds rgb_in, modulo 2^16, on every px_valid sample.
  - On each v edge in LOCKED, frame_sum <= accumulator and the accumulator clears.
  - The accumulator also clears on SEARCH.
- **VGA_RX_SUM_EN undefined:** no accumulator is built and frame_sum is constant 0.

## Test plan
- **Lock and coordinates:** standard 800x525 timing, pix_en every 2nd clock, LOCK_FRAMES=2 -> locked rises at the 3rd vsync fall; frame_done pulses once per frame thereafter; line_len=800 and frame_lines=525.
- **Active window:** colour bars -> first px_valid at h=143, v=34 with px_x=0 and px_y=0; last at px_x=639, px_y=479; exactly 307200 px_valid pulses per frame.
- **Short line:** one 799-pixel line mid-frame while locked -> sync_err pulse at that hsync fall; locked=0; relock after 3 further vsync falls.
- **Stuck hsync:** hsync held at 1 while locked -> sync_err when h_ctr reaches 1023, i.e. 1023 samples after the last edge; no frame_done.
- **Mid-frame reset:** rst_n low for 1 clock at line 200 -> all outputs 0 the next clock; locked does not return before the 3rd subsequent vsync fall.
- **Checksum (VGA_RX_SUM_EN):** rgb_in=1 constant -> frame_sum=45056 (307200 mod 65536) after each locked frame; rgb_in=7 -> 53248.
